branch_predictor: RTL and testbench
===================================

# branch_predictor

- Parametrised dynamic branch predictor for the fetch stage of the pipelined MIPS core.
- Replaces the fixed predict-not-taken/flush-on-branch policy with:
  - a direct-mapped table of 2-bit saturating counters;
  - an optional tagged branch target buffer.
- Lookup is combinational against the IF-stage PC. Update is registered from the EX/MEM resolution point.
- Keeps a saturating mispredict counter for performance debug.

## Interface

Parameters:
- ADDR_W, 32, PC width. PC is a word address; it increments by 1.
- INDEX_W, 4, index bits. Table depth is 2^INDEX_W entries.
- TAG_W, 6, BTB tag bits. Unused without BTB.
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- lookup_valid  in  1  IF-stage lookup request.
- lookup_pc  in  ADDR_W  PC being fetched.
- pred_taken  out  1  predicted direction.
- pred_target  out  ADDR_W  predicted target.
- pred_hit  out  1  entry valid and tag match.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual branch or jump target.
- mispred_cnt  out  16  saturating count of mispredicted updates.

## Operation

- Address split:
  - index = pc[INDEX_W-1:0];
  - tag = pc[INDEX_W+TAG_W-1:INDEX_W].
- Each entry holds cnt[1:0]. With BTB it also holds valid, tag[TAG_W-1:0] and target[ADDR_W-1:0].
- Lookup is purely combinational:
  - pred_hit = lookup_valid & valid[idx] & (tag[idx]==lookup tag);
  - pred_taken = pred_hit & cnt[idx][1];
  - pred_target = target[idx] when pred_hit, else 0.
- When lookup_valid=0, all three outputs are 0.
- Update, on a rising edge with upd_valid=1 and reset=0:
  - Hit, taken: cnt increments, saturating at 2'b11. target is overwritten with upd_target.
  - Hit, not taken: cnt decrements, saturating at 2'b00. target is unchanged.
  - Miss, taken: the entry is allocated, overwriting any previous occupant. valid=1, tag written, target=upd_target, cnt=2'b10.
  - Miss, not taken: no change.
- Mispredict at update:
  - Defined as upd_taken != (hit_u & cnt[idx_u][1]), evaluated on the pre-update entry.
  - Also counts as a mispredict: hit_u & upd_taken & cnt[idx_u][1] & (target != upd_target).
  - Each mispredict increments mispred_cnt by 1, saturating at 16'hFFFF.
- Table size is fixed at 2^INDEX_W entries. Aliasing between PCs with equal index is allowed: counters are shared, and tags disambiguate only the BTB.

## Timing

- Lookup latency: 0 cycles, combinational from lookup_pc to the pred_* outputs.
- Update latency: 1 cycle. State is written at the rising edge where upd_valid=1.
- Simultaneous lookup and update to the same index:
  - lookup returns the pre-update value;
  - there is no bypass;
  - the new value is visible from the next cycle.
- Reset is synchronous and has priority over update. On the reset edge:
  - every cnt is set to CNT_INIT;
  - every valid is cleared;
  - mispred_cnt is set to 0.
- Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0.
- An update asserted in the same cycle as reset is discarded.
- Reset asserted mid-stream leaves no partial state.
- No handshake. upd_valid is a single-cycle strobe, and at most one update occurs per cycle.

## Configuration

- Macro BRANCH_PREDICTOR_BTB_EN.
- Defined:
  - the tag, valid and target arrays are built;
  - behaviour is as above.
- Undefined:
  - no tag, valid or target storage;
  - every entry is treated as a hit, so pred_hit = lookup_valid and pred_taken = lookup_valid & cnt[idx][1];
  - pred_target is constant 0, and the core computes the target in ID;
  - updates always adjust cnt, with no allocation rule;
  - the target-mismatch mispredict term is omitted.

## Test plan

- Reset, then lookup pc=0x05: pred_hit=0, pred_taken=0, pred_target=0, mispred_cnt=0.
- Branch at pc=0x05 taken to 0x40 (allocation), then lookup 0x05:
  - after the first update: hit=1, taken=1, target=0x40, mispred_cnt=1;
  - after a second taken update: cnt=2'b11, mispred_cnt stays 1.
- Counter saturation, starting from cnt=2'b11 at pc=0x05:
  - three not-taken updates take cnt 11→10→01→00, so pred_taken=0 after the second;
  - a fourth not-taken update leaves cnt=00, with no underflow.
- Alias and collision:
  - after allocating pc=0x05, apply a taken update for pc=0x15 (same index, different tag) with target 0x80;
  - lookup 0x05 then misses; lookup 0x15 hits with target 0x80 and cnt=2'b10.
- Same-cycle collision and reset priority:
  - with update and lookup on the same index in one cycle, lookup shows the old cnt, and the new cnt appears the next cycle;
  - with reset and upd_valid in the same cycle, the table is cleared and mispred_cnt=0.
- mispred_cnt saturation: force 65536 mispredicts; the count holds at 16'hFFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter branch predictor with optional BTB (BRANCH_PREDICTOR_BTB_EN)
module branch_predictor #(
    parameter int          ADDR_W   = 32,
    parameter int          INDEX_W  = 4,
    parameter int          TAG_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic              pred_hit,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [15:0]       mispred_cnt
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [1:0]         cnt [DEPTH];
    logic [INDEX_W-1:0] idx_l;
    logic [INDEX_W-1:0] idx_u;
    logic               hit_l;
    logic               hit_u;
    logic               mispred;
    logic               unused_ok;

    assign idx_l     = lookup_pc[INDEX_W-1:0];
    assign idx_u     = upd_pc[INDEX_W-1:0];
    assign unused_ok = ^{lookup_pc, upd_pc, upd_target, (TAG_W > 0)};

`ifdef BRANCH_PREDICTOR_BTB_EN
    logic [DEPTH-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem    [DEPTH];
    logic [ADDR_W-1:0] target_mem [DEPTH];
    logic [TAG_W-1:0]  tag_l;
    logic [TAG_W-1:0]  tag_u;

    assign tag_l       = lookup_pc[INDEX_W+TAG_W-1:INDEX_W];
    assign tag_u       = upd_pc[INDEX_W+TAG_W-1:INDEX_W];
    assign hit_l       = lookup_valid & valid[idx_l] & (tag_mem[idx_l] == tag_l);
    assign hit_u       = valid[idx_u] & (tag_mem[idx_u] == tag_u);
    assign pred_target = hit_l ? target_mem[idx_l] : '0;
    // A correctly predicted direction still mispredicts if the cached target is stale.
    assign mispred     = upd_valid &
                         ((upd_taken != (hit_u & cnt[idx_u][1])) |
                          (hit_u & upd_taken & cnt[idx_u][1] & (target_mem[idx_u] != upd_target)));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (upd_valid && upd_taken) begin
            target_mem[idx_u] <= upd_target;
            if (!hit_u) begin
                valid[idx_u]   <= 1'b1;
                tag_mem[idx_u] <= tag_u;
            end
        end
    end
`else
    // Without a BTB every entry counts as a hit; the core computes targets in ID.
    assign hit_l       = lookup_valid;
    assign hit_u       = 1'b1;
    assign pred_target = '0;
    assign mispred     = upd_valid & (upd_taken != cnt[idx_u][1]);
`endif

    assign pred_hit   = hit_l;
    assign pred_taken = hit_l & cnt[idx_l][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= CNT_INIT;
            end
            mispred_cnt <= '0;
        end else begin
            if (upd_valid) begin
                if (hit_u) begin
                    if (upd_taken && cnt[idx_u] != 2'b11) begin
                        cnt[idx_u] <= cnt[idx_u] + 2'd1;
                    end else if (!upd_taken && cnt[idx_u] != 2'b00) begin
                        cnt[idx_u] <= cnt[idx_u] - 2'd1;
                    end
                end else if (upd_taken) begin
                    cnt[idx_u] <= 2'b10;
                end
            end
            if (mispred && mispred_cnt != 16'hFFFF) begin
                mispred_cnt <= mispred_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized bench for branch_predictor against a table-level reference model
module tb_branch_predictor;
`ifdef BRANCH_PREDICTOR_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: counters kept as plain integers 0..3
    int          m_cnt   [16];
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_mis;

    branch_predictor dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .pred_hit     (pred_hit),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .mispred_cnt  (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        int idx = int'(pc % 16);
        int tg  = int'((pc / 16) % 64);
        if (!BTB) return 1'b1;
        return m_valid[idx] && (m_tag[idx] == tg);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_cnt[i]   = 1;
            m_valid[i] = 1'b0;
        end
        m_mis = 0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int idx = int'(pc % 16);
        bit hit = m_hit(pc);
        bit pred = hit && (m_cnt[idx] >= 2);
        bit mis  = (taken != pred) || (BTB && pred && taken && (m_tgt[idx] != tgt));
        if (mis && m_mis < 65535) m_mis++;
        if (hit) begin
            if (taken) begin
                if (m_cnt[idx] < 3) m_cnt[idx]++;
                m_tgt[idx] = tgt;
            end else if (m_cnt[idx] > 0) begin
                m_cnt[idx]--;
            end
        end else if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = int'((pc / 16) % 64);
            m_tgt[idx]   = tgt;
            m_cnt[idx]   = 2;
        end
    endfunction

    // One cycle: drive at negedge, check pre-edge outputs, then advance the model at the edge.
    task automatic step(input bit rst, input bit lv, input logic [31:0] lpc,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt, input bit chk_lookup);
        bit          e_hit;
        logic [31:0] e_tgt;
        @(negedge clk);
        reset = rst; lookup_valid = lv; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        #1;
        if (chk_lookup) begin
            e_hit = lv && m_hit(lpc);
            e_tgt = (e_hit && BTB) ? m_tgt[int'(lpc % 16)] : 32'h0;
            check("pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
            check("pred_taken", {31'b0, pred_taken}, {31'b0, e_hit && (m_cnt[int'(lpc % 16)] >= 2)});
            check("pred_target", pred_target, e_tgt);
        end
        check("mispred_cnt", {16'b0, mispred_cnt}, m_mis);
        @(posedge clk);
        if (rst) m_reset();
        else if (uv) m_update(upc, ut, utgt);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, 1'b1, pc, taken, tgt, 1'b1);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 32'h05, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("reset_taken", {31'b0, pred_taken}, 32'd0);
        check("reset_target", pred_target, 32'd0);
        check("reset_mis", {16'b0, mispred_cnt}, 32'd0);
        check("reset_hit", {31'b0, pred_hit}, BTB ? 32'd0 : 32'd1);
        look(32'h15);
        step(1'b0, 1'b0, 32'h05, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Allocation and strengthening
        upd(32'h05, 1'b1, 32'h40);
        look(32'h05);
        check("alloc_taken", {31'b0, pred_taken}, 32'd1);
        check("alloc_target", pred_target, BTB ? 32'h40 : 32'h0);
        check("alloc_mis", {16'b0, mispred_cnt}, 32'd1);
        upd(32'h05, 1'b1, 32'h40);
        look(32'h05);
        check("strong_mis", {16'b0, mispred_cnt}, 32'd1);

        // Saturation downwards
        for (int i = 0; i < 4; i++) begin
            upd(32'h05, 1'b0, 32'h0);
            look(32'h05);
        end
        check("floor_taken", {31'b0, pred_taken}, 32'd0);
        upd(32'h05, 1'b1, 32'h44);
        look(32'h05);

        // Alias at the same index with a different tag
        upd(32'h05, 1'b1, 32'h40);
        upd(32'h15, 1'b1, 32'h80);
        look(32'h05);
        look(32'h15);
        check("alias_taken", {31'b0, pred_taken}, 32'd1);

        // Same-cycle lookup and update: old value now, new value next cycle
        step(1'b0, 1'b1, 32'h15, 1'b1, 32'h15, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h15, 1'b1, 32'h15, 1'b0, 32'h0, 1'b1);
        look(32'h15);
        check("collide_taken", {31'b0, pred_taken}, 32'd0);

        // Reset wins over a concurrent update
        step(1'b1, 1'b1, 32'h15, 1'b1, 32'h15, 1'b1, 32'h99, 1'b1);
        look(32'h15);
        check("rst_upd_mis", {16'b0, mispred_cnt}, 32'd0);
        check("rst_upd_target", pred_target, 32'd0);

        // Randomized traffic with aliasing and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] lpc = $urandom_range(0, 63);
            logic [31:0] upc = $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) lpc = lpc | 32'hFFFF_0000;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, lpc,
                 $urandom_range(0, 2) != 0, upc, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) << 4, 1'b1);
        end

        // Every alternating update at a fresh index mispredicts; drive past saturation.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 32'h07, (i % 2) == 0, 32'h70, 1'b0);
        end
        look(32'h07);
        check("mis_sat", {16'b0, mispred_cnt}, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
